// File: rtl/store_unit.sv
// MEM-stage store path: packs a store into a word-aligned bus write with byte
// enables, runs the req/ack handshake, and flags misaligned stores and timeouts.
module store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        exc_ades,
  output logic [31:0] badvaddr,
  output logic        done,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             misaligned, valid, accept, timeout_hit;
  logic [3:0]       pack_be;
  logic [31:0]      pack_data;

  assign misaligned  = (op == 2'b01 && addr[0]) || (op == 2'b00 && addr[1:0] != 2'b00);
  assign valid       = req && !flush && op != 2'b11;
  assign accept      = (state == IDLE) && valid && !misaligned;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Little-endian lane packing; the data is replicated so any enabled lane sees it.
  always_comb begin
    pack_be   = 4'b0000;
    pack_data = wdata;
    case (op)
      2'b00: begin
        pack_be   = 4'b1111;
        pack_data = wdata;
      end
      2'b01: begin
        pack_be   = addr[1] ? 4'b1100 : 4'b0011;
        pack_data = {2{wdata[15:0]}};
      end
      2'b10: begin
        pack_be   = 4'b0001 << addr[1:0];
        pack_data = {4{wdata[7:0]}};
      end
      default: begin
        pack_be   = 4'b0000;
        pack_data = wdata;
      end
    endcase
  end

  // Ack has priority over timeout; an issued write is never cancelled by new inputs.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    exc_ades   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          next_state = BUSY;
        end else if (valid && misaligned) begin
          exc_ades = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack || timeout_hit) begin
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      badvaddr  <= 32'h0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state   <= next_state;
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_req   <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= pack_be;
            mem_wdata <= pack_data;
            cnt       <= '0;
          end else if (exc_ades) begin
            badvaddr <= addr;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_be  <= 4'b0000;
            done    <= 1'b1;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_be  <= 4'b0000;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: packing, handshake latency, misalignment,
// timeout, back-to-back stores, flush and asynchronous reset during a write.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        exc_ades;
  logic [31:0] badvaddr;
  logic        done;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  int done_pulses = 0;
  bit stalled_out;

  store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .stall(stall), .exc_ades(exc_ades),
    .badvaddr(badvaddr), .done(done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stall) stall_cycles++;
    if (done) done_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] d, input logic f, input logic ack);
    req = r; op = o; addr = a; wdata = d; flush = f; mem_ack = ack;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req = 0; op = 0; addr = 0; wdata = 0; flush = 0; mem_ack = 0;
    repeat (3) tick();
    checkOutput("rst_mem_req",  32'(mem_req),  32'h0);
    checkOutput("rst_mem_be",   32'(mem_be),   32'h0);
    checkOutput("rst_mem_addr", mem_addr,      32'h0);
    checkOutput("rst_wdata",    mem_wdata,     32'h0);
    checkOutput("rst_badv",     badvaddr,      32'h0);
    checkOutput("rst_done_err", {done, bus_err}, 32'h0);
    checkOutput("rst_stall",    32'(stall),    32'h0);
    reset = 1'b1;
    tick();

    // sb to 0x1003, ack in the first mem_req cycle
    stall_cycles = 0; done_pulses = 0;
    applyStimulus(1, 2'b10, 32'h0000_1003, 32'h1234_5678, 0, 0);
    checkOutput("sb_accept_stall", 32'(stall), 32'h1);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    checkOutput("sb_mem_req",   32'(mem_req), 32'h1);
    checkOutput("sb_mem_addr",  mem_addr,     32'h0000_1000);
    checkOutput("sb_mem_be",    32'(mem_be),  32'h8);
    checkOutput("sb_mem_wdata", mem_wdata,    32'h7878_7878);
    checkOutput("sb_ack_stall", 32'(stall),   32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("sb_done",      32'(done),    32'h1);
    checkOutput("sb_req_low",   32'(mem_req), 32'h0);
    checkOutput("sb_be_clear",  32'(mem_be),  32'h0);
    tick();
    checkOutput("sb_done_once", 32'(done),    32'h0);
    checkOutput("sb_stall_cnt", 32'(stall_cycles), 32'd1);
    checkOutput("sb_done_cnt",  32'(done_pulses),  32'd1);

    // sh to 0x2002, ack on the fourth mem_req cycle
    stall_cycles = 0;
    applyStimulus(1, 2'b01, 32'h0000_2002, 32'hAAAA_BEEF, 0, 0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sh_hold_req%0d", i),   32'(mem_req), 32'h1);
      checkOutput($sformatf("sh_hold_be%0d", i),    32'(mem_be),  32'hC);
      checkOutput($sformatf("sh_hold_data%0d", i),  mem_wdata,    32'hBEEF_BEEF);
      checkOutput($sformatf("sh_hold_addr%0d", i),  mem_addr,     32'h0000_2000);
      checkOutput($sformatf("sh_hold_stall%0d", i), 32'(stall),   32'h1);
      tick();
    end
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    checkOutput("sh_last_req",   32'(mem_req), 32'h1);
    checkOutput("sh_last_be",    32'(mem_be),  32'hC);
    checkOutput("sh_ack_stall",  32'(stall),   32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("sh_done",      32'(done),         32'h1);
    checkOutput("sh_stall_cnt", 32'(stall_cycles), 32'd4);
    tick();

    // misaligned sh and sw
    applyStimulus(1, 2'b01, 32'h0000_0005, 32'h0, 0, 0);
    checkOutput("ades_sh_exc",   32'(exc_ades), 32'h1);
    checkOutput("ades_sh_stall", 32'(stall),    32'h0);
    tick();
    checkOutput("ades_sh_badv",  badvaddr,      32'h0000_0005);
    checkOutput("ades_sh_req",   32'(mem_req),  32'h0);
    applyStimulus(1, 2'b00, 32'h0000_0006, 32'h0, 0, 0);
    checkOutput("ades_sw_exc",   32'(exc_ades), 32'h1);
    checkOutput("ades_sw_stall", 32'(stall),    32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("ades_sw_badv",  badvaddr,      32'h0000_0006);
    checkOutput("ades_sw_req",   32'(mem_req),  32'h0);
    checkOutput("ades_clear",    32'(exc_ades), 32'h0);

    // reserved op with a misaligned address does nothing
    applyStimulus(1, 2'b11, 32'h0000_0003, 32'h0, 0, 0);
    checkOutput("rsv_stall_exc", {stall, exc_ades}, 32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("rsv_req", 32'(mem_req), 32'h0);

    // sw with no ack: 16 stall cycles then bus_err
    stall_cycles = 0;
    applyStimulus(1, 2'b00, 32'h0000_0040, 32'h0BAD_0BAD, 0, 0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    stalled_out = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) begin
        stalled_out = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("to_bounded",   32'(stalled_out),  32'h1);
    checkOutput("to_stall_cnt", 32'(stall_cycles), 32'd16);
    tick();
    checkOutput("to_bus_err",   32'(bus_err),      32'h1);
    checkOutput("to_req_low",   32'(mem_req),      32'h0);
    checkOutput("to_no_done",   32'(done),         32'h0);
    applyStimulus(1, 2'b00, 32'h0000_0044, 32'h1111_2222, 0, 0);
    checkOutput("to_next_stall", 32'(stall), 32'h1);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    checkOutput("to_err_once",  32'(bus_err),  32'h0);
    checkOutput("to_next_addr", mem_addr,      32'h0000_0044);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("to_next_done", 32'(done), 32'h1);
    tick();

    // ack arriving on the timeout cycle wins
    applyStimulus(1, 2'b00, 32'h0000_0048, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    repeat (15) tick();
    checkOutput("race_last_cycle", {mem_req, stall}, 32'h2);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("race_done_err", {done, bus_err}, 32'h2);
    tick();

    // back-to-back sw 0x10 then sb 0x13
    applyStimulus(1, 2'b00, 32'h0000_0010, 32'hCAFE_F00D, 0, 0);
    tick();
    applyStimulus(1, 2'b10, 32'h0000_0013, 32'h0000_000D, 0, 1);
    checkOutput("b2b_w1_be",    32'(mem_be),  32'hF);
    checkOutput("b2b_w1_data",  mem_wdata,    32'hCAFE_F00D);
    checkOutput("b2b_w1_stall", 32'(stall),   32'h0);
    tick();
    applyStimulus(1, 2'b10, 32'h0000_0013, 32'h0000_000D, 0, 0);
    checkOutput("b2b_w1_done",  32'(done),    32'h1);
    checkOutput("b2b_accept2",  32'(stall),   32'h1);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    checkOutput("b2b_w2_req",   32'(mem_req), 32'h1);
    checkOutput("b2b_w2_be",    32'(mem_be),  32'h8);
    checkOutput("b2b_w2_addr",  mem_addr,     32'h0000_0010);
    checkOutput("b2b_w2_data",  mem_wdata,    32'h0D0D_0D0D);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("b2b_w2_done",  32'(done),    32'h1);

    // flush kills a store in IDLE
    applyStimulus(1, 2'b00, 32'h0000_0020, 32'h5555_5555, 1, 0);
    checkOutput("flush_stall_exc", {stall, exc_ades}, 32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("flush_no_req", 32'(mem_req), 32'h0);

    // asynchronous reset in the middle of a write
    done_pulses = 0;
    applyStimulus(1, 2'b00, 32'h0000_0080, 32'h7777_7777, 0, 0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    checkOutput("rb_req_before", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("rb_req",   32'(mem_req), 32'h0);
    checkOutput("rb_be",    32'(mem_be),  32'h0);
    checkOutput("rb_addr",  mem_addr,     32'h0);
    checkOutput("rb_flags", {done, bus_err, stall}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1);
    checkOutput("rb_late_ack_stall", 32'(stall), 32'h0);
    tick();
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0);
    tick();
    checkOutput("rb_no_done",  32'(done_pulses), 32'd0);
    checkOutput("rb_req_idle", 32'(mem_req),     32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- MEM-stage store path of the pipeline CPU, the narrowing counterpart of the immediate/load extenders.
- Takes a 32-bit store value plus a byte address and packs it into a word-aligned data-bus write with byte enables.
- Runs a req/ack handshake with data memory and stalls the pipeline until the write completes.
- Reports misaligned stores (AdES) and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles a write may wait for mem_ack before bus_err (≥2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  MEM-stage store instruction valid
op  in  2  00 sw, 01 sh, 10 sb, 11 reserved
addr  in  32  byte address from ALU
wdata  in  32  register value to store
flush  in  1  kill the MEM-stage instruction this cycle
mem_ack  in  1  memory write accepted
mem_req  out  1  write request to memory (registered)
mem_addr  out  32  {addr[31:2],2'b00} (registered)
mem_be  out  4  byte enables, bit k = byte lane k (registered)
mem_wdata  out  32  lane-replicated data (registered)
stall  out  1  freeze IF..MEM this cycle (combinational)
exc_ades  out  1  store address error (combinational)
badvaddr  out  32  faulting address (registered)
done  out  1  one-cycle pulse after a completed write (registered)
bus_err  out  1  one-cycle pulse on timeout (registered)

Behaviour:
- Reset (async, reset=0): state IDLE, counter 0. mem_req, mem_be, done, bus_err = 0. mem_addr, mem_wdata, badvaddr = 0.
- Little-endian lanes. Misaligned = (op==01 & addr[0]) | (op==00 & addr[1:0]!=0).
- Packing:
  - sw: be=1111, data=wdata.
  - sh: be=0011 if addr[1]=0 else 1100, data={2{wdata[15:0]}}.
  - sb: be=1<<addr[1:0], data={4{wdata[7:0]}}.
- FSM IDLE:
  - Accept when req & !flush & op!=11 & !misaligned: latch packed mem_*, mem_req=1 from next cycle, counter=0, go BUSY. stall=1 in the accept cycle.
  - req & !flush & op!=11 & misaligned: exc_ades=1 same cycle, badvaddr<=addr at edge, no bus activity, stall=0.
  - op==11 or flush or !req: no effect, stall=0, exc_ades=0.
- FSM BUSY:
  - mem_* held stable. Inputs req/op/addr/wdata/flush ignored; an issued write is never cancelled.
  - mem_ack=1: stall=0 that cycle, mem_req<=0, mem_be<=0, done<=1 next cycle, go IDLE.
  - No ack and counter==TIMEOUT-1: stall=0 that cycle, mem_req<=0, bus_err<=1 next cycle, go IDLE.
  - Otherwise: stall=1, counter+1.
- Ack and timeout in the same cycle: ack wins (done, no bus_err).
- mem_ack while IDLE is ignored.
- Minimum latency: accept at cycle N, mem_req high N+1. Ack at N+1 gives 1 stall cycle and done at N+2.
- A req present in the cycle after return to IDLE is a new instruction and may be accepted immediately (back-to-back stores).
- Reset mid-BUSY: all outputs to reset values asynchronously; the pending write is dropped.

Test Plan:
- sb addr=0x0000_1003, wdata=0x1234_5678, ack 1 cycle after mem_req → mem_addr=0x0000_1000, be=1000, mem_wdata=0x7878_7878, stall exactly 1 cycle, done pulse once.
- sh addr=0x0000_2002, wdata=0xAAAA_BEEF, ack delayed 3 cycles → be=1100, mem_wdata=0xBEEF_BEEF, mem_* stable over 4 mem_req cycles, stall=4 cycles.
- sh addr=0x0000_0005 and sw addr=0x0000_0006 → exc_ades=1 each cycle, badvaddr=0x5 then 0x6, mem_req never rises, stall=0.
- sw, mem_ack held 0, TIMEOUT=16 → stall high for 16 cycles (accept + 15), bus_err pulse, mem_req low, FSM accepts next store.
- Back-to-back sw to 0x10 and sb to 0x13 with immediate acks → two writes, be 1111 then 1000, no idle bubble between accepts. flush with req in IDLE → no write.
- reset driven low during BUSY → mem_req/mem_be/done/bus_err 0 immediately. After release, a late mem_ack is ignored and no done occurs.
